mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, line address width (128-bit line granularity).
REQ-002 Parameter DATA_W, default 128, line data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 proc_reset  input  1  synchronous, active-high reset.
REQ-005 i_mem_read / i_mem_write  input  1 each  instruction-cache line request.
REQ-006 i_mem_addr  input  ADDR_W; i_mem_wdata  input  DATA_W  instruction-cache address and write data.
REQ-007 i_mem_rdata  output  DATA_W; i_mem_ready  output  1  instruction-cache return path.
REQ-008 d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: data-cache port; same widths and directions as the i_ port.
REQ-009 mem_read, mem_write  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  shared memory command.
REQ-010 mem_rdata  input  DATA_W; mem_ready  input  1  shared memory response.

Function
REQ-011 Per-port request = x_mem_read | x_mem_write; read, write, addr and wdata are forwarded unmodified.
REQ-012 FSM states: IDLE, GRANT_I, GRANT_D, DONE; registered owner bit and last_grant bit.
REQ-013 IDLE: all mem_* outputs 0; no request -> stay IDLE; one request -> that GRANT state next cycle; both -> priority per REQ-025.
REQ-014 Arbitration latency: request first seen in IDLE at cycle t -> mem_read/mem_write asserted at t+1.
REQ-015 GRANT_x: mem_* driven combinationally from port x; other port's request ignored and left pending.
REQ-016 GRANT_x: x_mem_ready = mem_ready (combinational); x_mem_rdata = mem_rdata.
REQ-017 GRANT_x with mem_ready=1: capture mem_rdata into rdata_q; owner <= x; last_grant <= x; next state DONE.
REQ-018 GRANT_x with request dropped before mem_ready: next state IDLE, no ready pulse, last_grant unchanged.
REQ-019 DONE (exactly 1 cycle): mem_* outputs 0; x_mem_ready = 1 for owner; x_mem_rdata = rdata_q; always -> IDLE.
REQ-020 DONE ensures a requester that samples ready through a register deasserts its request before re-arbitration; no spurious re-grant.
REQ-021 Non-owner port: ready 0, rdata 0 at all times.
REQ-022 mem_ready in IDLE or DONE is ignored.

Reset
REQ-023 proc_reset (any state, including mid-transaction) -> IDLE, last_grant = D, owner = I, rdata_q = 0 on next edge.
REQ-024 Outputs during and after reset: all mem_*, x_mem_ready, x_mem_rdata = 0 until a new grant.

Configuration
REQ-025 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the port that is not last_grant. Undefined: data port always wins; last_grant is still maintained but unused.

Structure
REQ-026 Package mem_arb_pkg holds ADDR_W/DATA_W defaults, the state enumeration (2-bit) and owner encoding (I=0, D=1).
REQ-027 Sub-module arb_pick: combinational two-requester selector (inputs: req_i, req_d, last_grant; output: grant_d), with the macro applied inside it.

Verification
REQ-028 Only i_mem_read=1, addr 0x0000010; memory asserts mem_ready 3 cycles later with rdata 0xA5..A5 -> mem_read high 3 cycles, i_mem_ready high 2 cycles (GRANT, DONE), i_mem_rdata=0xA5..A5 in both.
REQ-029 i and d both request in the same IDLE cycle, last_grant=D -> with macro: I served first, then D; without macro: D first.
REQ-030 Back-to-back: d_mem_write held 1 cycle after DONE -> re-granted to D only via a fresh IDLE cycle; 2-cycle gap between mem_write pulses.
REQ-031 proc_reset asserted in GRANT_D while mem_read=1 -> next cycle IDLE, all outputs 0; late mem_ready is ignored.
REQ-032 Requester drops i_mem_read in GRANT_I before mem_ready -> IDLE next cycle, no i_mem_ready pulse, pending d request granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default line address and line data widths
//   arb_state_t                     : arbiter FSM state encoding (2-bit)
//   owner_t                         : port identity, I = 0, D = 1
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT = 28;
  localparam int DATA_W_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational selector between the instruction and data requesters.
//   req_i, req_d : pending requests from each port
//   last_grant   : port that completed the most recent transaction
//   grant_d      : 1 selects the data port, 0 the instruction port
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to
// the port that was not served last; otherwise the data port always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_grant,
  output logic   grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign grant_d = req_d & (~req_i | (last_grant == OWNER_I));
`else
  // Fixed priority: req_i and last_grant are not needed for the decision.
  logic unused_pick_inputs;
  assign unused_pick_inputs = ^{req_i, last_grant};
  assign grant_d = req_d;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-granular memory port between an instruction
// cache (i_*) and a data cache (d_*).
//   clk, proc_reset                 : clock, synchronous active-high reset
//   i_mem_read/write/addr/wdata     : instruction-cache request
//   i_mem_rdata, i_mem_ready        : instruction-cache response
//   d_mem_*                         : data-cache port, same shape as i_*
//   mem_read/write/addr/wdata       : shared memory command
//   mem_rdata, mem_ready            : shared memory response
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of
// data-first priority (applied inside arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state;
  owner_t            owner;
  owner_t            last_grant;
  logic [DATA_W-1:0] rdata_q;
  logic              req_i;
  logic              req_d;
  logic              grant_d;

  assign req_i = i_mem_read | i_mem_write;
  assign req_d = d_mem_read | d_mem_write;

  arb_pick u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant_d    (grant_d)
  );

  // A granted port that drops its request before mem_ready abandons the
  // transaction: back to IDLE with no ready pulse and last_grant untouched.
  // DONE always returns through IDLE so a requester that registers ready has
  // a cycle to deassert before it can be arbitrated again.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      owner      <= OWNER_I;
      last_grant <= OWNER_D;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i | req_d) state <= grant_d ? GRANT_D : GRANT_I;
        end
        GRANT_I: begin
          if (!req_i) begin
            state <= IDLE;
          end else if (mem_ready) begin
            rdata_q    <= mem_rdata;
            owner      <= OWNER_I;
            last_grant <= OWNER_I;
            state      <= DONE;
          end
        end
        GRANT_D: begin
          if (!req_d) begin
            state <= IDLE;
          end else if (mem_ready) begin
            rdata_q    <= mem_rdata;
            owner      <= OWNER_D;
            last_grant <= OWNER_D;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held so a mid-transaction reset
  // never leaks a command or ready pulse.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    d_mem_ready = 1'b0;
    d_mem_rdata = '0;
    if (!proc_reset) begin
      case (state)
        GRANT_I: begin
          mem_read    = i_mem_read;
          mem_write   = i_mem_write;
          mem_addr    = i_mem_addr;
          mem_wdata   = i_mem_wdata;
          i_mem_ready = mem_ready;
          i_mem_rdata = mem_rdata;
        end
        GRANT_D: begin
          mem_read    = d_mem_read;
          mem_write   = d_mem_write;
          mem_addr    = d_mem_addr;
          mem_wdata   = d_mem_wdata;
          d_mem_ready = mem_ready;
          d_mem_rdata = mem_rdata;
        end
        DONE: begin
          if (owner == OWNER_D) begin
            d_mem_ready = 1'b1;
            d_mem_rdata = rdata_q;
          end else begin
            i_mem_ready = 1'b1;
            i_mem_rdata = rdata_q;
          end
        end
        default: begin
          mem_read = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a scripted memory
// model and a scoreboard of expected completed transactions.
module tb_mem_arbiter;

  logic         clk;
  logic         proc_reset;
  logic         i_mem_read, i_mem_write;
  logic [27:0]  i_mem_addr;
  logic [127:0] i_mem_wdata, i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read, d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata, d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  mem_arbiter dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_mem_addr  (i_mem_addr),
    .i_mem_wdata (i_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .d_mem_ready (d_mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           port;
    logic [27:0]  addr;
    bit           write;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_done;
  bit   done_expected;

  int tests_run;
  int tests_failed;
  int cyc;

  int busy;
  int mem_lat;
  bit force_ready;
  bit drop_i_on_ready, drop_d_on_ready;
  bit drop_pending_i, drop_pending_d;

  int mem_read_cycles, i_ready_cycles, d_ready_cycles;
  int first_cmd_cyc;
  int last_wr_high, wr_gap;
  bit wr_prev;

  logic        s_mem_read;
  logic [27:0] s_mem_addr;
  logic [7:0]  s_all_out;

  function automatic logic [127:0] pattern(input logic [27:0] a);
    if (a == 28'h10) return {16{8'hA5}};
    return {4{{4'h0, a} ^ 32'h3C3C_0000}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Samples the DUT mid-cycle: snapshot, counters, scoreboard and DONE checks.
  task automatic monitor();
    exp_t e;
    s_mem_read = mem_read;
    s_mem_addr = mem_addr;
    s_all_out  = {mem_read, mem_write, i_mem_ready, d_mem_ready,
                  |mem_addr, |mem_wdata, |i_mem_rdata, |d_mem_rdata};
    if (mem_read) mem_read_cycles++;
    if (i_mem_ready) i_ready_cycles++;
    if (d_mem_ready) d_ready_cycles++;
    if ((mem_read || mem_write) && first_cmd_cyc < 0) first_cmd_cyc = cyc;
    if (mem_write && !wr_prev && last_wr_high >= 0) wr_gap = cyc - last_wr_high - 1;
    if (mem_write) last_wr_high = cyc;
    wr_prev = mem_write;
    if (!i_mem_ready) checkOutput("i_rdata_without_ready", i_mem_rdata, '0);
    if (!d_mem_ready) checkOutput("d_rdata_without_ready", d_mem_rdata, '0);

    if (done_expected) begin
      done_expected = 1'b0;
      checkOutput("done_ready", 128'(last_done.port ? d_mem_ready : i_mem_ready), 128'(1));
      checkOutput("done_other_ready", 128'(last_done.port ? i_mem_ready : d_mem_ready), 128'(0));
      checkOutput("done_rdata", last_done.port ? d_mem_rdata : i_mem_rdata, last_done.rdata);
      checkOutput("done_mem_cmd", 128'({mem_read, mem_write}), 128'(0));
    end else if (mem_ready && (mem_read || mem_write)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_txn", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        checkOutput("txn_port", 128'({d_mem_ready, i_mem_ready}), 128'(e.port ? 2'b10 : 2'b01));
        checkOutput("txn_addr", 128'(mem_addr), 128'(e.addr));
        checkOutput("txn_write", 128'(mem_write), 128'(e.write));
        if (e.write) checkOutput("txn_wdata", mem_wdata, e.wdata);
        checkOutput("txn_rdata", e.port ? d_mem_rdata : i_mem_rdata, e.rdata);
        last_done     = e;
        done_expected = 1'b1;
        if (e.port && drop_d_on_ready) drop_pending_d = 1'b1;
        if (!e.port && drop_i_on_ready) drop_pending_i = 1'b1;
      end
    end else if (i_mem_ready || d_mem_ready) begin
      checkOutput("spurious_ready", 128'(1), 128'(0));
    end
  endtask

  // One clock cycle, entered and left at posedge+1 with inputs already set.
  task automatic runCycle();
    #1;
    if (mem_read || mem_write) busy++;
    else busy = 0;
    mem_ready = force_ready || (busy == mem_lat);
    mem_rdata = mem_ready ? pattern(mem_addr) : '0;
    #1;
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (drop_pending_i) begin
      i_mem_read = 1'b0; i_mem_write = 1'b0; drop_pending_i = 1'b0;
    end
    if (drop_pending_d) begin
      d_mem_read = 1'b0; d_mem_write = 1'b0; drop_pending_d = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit port, input bit write, input logic [27:0] addr,
                               input logic [127:0] wdata, input bit expect_txn);
    exp_t e;
    if (port) begin
      d_mem_read = !write; d_mem_write = write; d_mem_addr = addr; d_mem_wdata = wdata;
    end else begin
      i_mem_read = !write; i_mem_write = write; i_mem_addr = addr; i_mem_wdata = wdata;
    end
    if (expect_txn) begin
      e.port = port; e.addr = addr; e.write = write; e.wdata = wdata; e.rdata = pattern(addr);
      exp_q.push_back(e);
    end
  endtask

  task automatic runUntilDrained(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || done_expected) && n < budget) begin
      runCycle();
      n++;
    end
    if (exp_q.size() != 0 || done_expected) begin
      checkOutput("drain_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      done_expected = 1'b0;
    end
  endtask

  task automatic doReset();
    proc_reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    d_mem_read = 1'b0; d_mem_write = 1'b0;
    drop_pending_i = 1'b0; drop_pending_d = 1'b0;
    runCycle();
    proc_reset = 1'b0;
  endtask

  task automatic clearCounters();
    mem_read_cycles = 0; i_ready_cycles = 0; d_ready_cycles = 0;
    first_cmd_cyc = -1; last_wr_high = -1; wr_gap = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cyc;
    tests_run = 0; tests_failed = 0; cyc = 0;
    busy = 0; mem_lat = 3; force_ready = 1'b0;
    drop_i_on_ready = 1'b1; drop_d_on_ready = 1'b1;
    drop_pending_i = 1'b0; drop_pending_d = 1'b0;
    done_expected = 1'b0; wr_prev = 1'b0;
    clearCounters();
    proc_reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0; i_mem_wdata = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset state: outputs quiet while held and in the IDLE cycle after.
    @(posedge clk); #1;
    runCycle();
    runCycle();
    checkOutput("reset_outputs", 128'(s_all_out), 128'(0));
    proc_reset = 1'b0;
    runCycle();
    checkOutput("idle_outputs", 128'(s_all_out), 128'(0));

    // Single instruction read with memory latency 3.
    doReset();
    clearCounters();
    req_cyc = cyc;
    applyStimulus(1'b0, 1'b0, 28'h10, '0, 1'b1);
    runUntilDrained(20);
    runCycle();
    checkOutput("i_read_latency", 128'(first_cmd_cyc - req_cyc), 128'(1));
    checkOutput("i_read_mem_read_cycles", 128'(mem_read_cycles), 128'(3));
    checkOutput("i_read_ready_cycles", 128'(i_ready_cycles), 128'(2));

    // Simultaneous requests right after reset (last_grant = D).
    doReset();
    clearCounters();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    applyStimulus(1'b0, 1'b0, 28'h20, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 28'h30, '0, 1'b1);
`else
    applyStimulus(1'b1, 1'b0, 28'h30, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 28'h20, '0, 1'b1);
`endif
    runUntilDrained(40);
    runCycle();
    checkOutput("both_i_ready_cycles", 128'(i_ready_cycles), 128'(2));
    checkOutput("both_d_ready_cycles", 128'(d_ready_cycles), 128'(2));

    // Back-to-back data writes: request held through DONE.
    clearCounters();
    drop_d_on_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 28'h40, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF, 1'b1);
    applyStimulus(1'b1, 1'b1, 28'h40, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF, 1'b1);
    for (int n = 0; n < 20 && exp_q.size() > 1; n++) runCycle();
    drop_d_on_ready = 1'b1;
    runUntilDrained(20);
    runCycle();
    runCycle();
    checkOutput("b2b_write_gap", 128'(wr_gap), 128'(2));
    checkOutput("b2b_d_ready_cycles", 128'(d_ready_cycles), 128'(4));

    // Reset during GRANT_D, then a late mem_ready that must be ignored.
    doReset();
    mem_lat = 100;
    applyStimulus(1'b1, 1'b0, 28'h50, '0, 1'b0);
    runCycle();
    runCycle();
    checkOutput("grant_d_mem_read", 128'(s_mem_read), 128'(1));
    proc_reset = 1'b1;
    runCycle();
    checkOutput("reset_mid_txn_outputs", 128'(s_all_out), 128'(0));
    proc_reset = 1'b0;
    d_mem_read = 1'b0;
    force_ready = 1'b1;
    runCycle();
    checkOutput("late_ready_ignored", 128'(s_all_out), 128'(0));
    force_ready = 1'b0;
    runCycle();
    checkOutput("after_reset_idle", 128'(s_all_out), 128'(0));
    mem_lat = 3;

    // Instruction request abandoned mid-grant; pending data request follows.
    doReset();
    clearCounters();
    mem_lat = 100;
    applyStimulus(1'b0, 1'b0, 28'h60, '0, 1'b0);
    runCycle();
    runCycle();
    checkOutput("abandon_grant_addr", 128'(s_mem_addr), 128'(28'h60));
    applyStimulus(1'b1, 1'b0, 28'h70, '0, 1'b1);
    runCycle();
    checkOutput("abandon_d_ignored", 128'(s_mem_addr), 128'(28'h60));
    i_mem_read = 1'b0;
    mem_lat = 3;
    runCycle();
    checkOutput("abandon_drop_cycle", 128'(s_mem_read), 128'(0));
    runCycle();
    checkOutput("abandon_idle_cycle", 128'(s_all_out), 128'(0));
    runCycle();
    checkOutput("abandon_d_granted", 128'({s_mem_read, s_mem_addr}), 128'({1'b1, 28'h70}));
    runUntilDrained(20);
    runCycle();
    checkOutput("abandon_no_i_ready", 128'(i_ready_cycles), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
